slicel_cfg_loader: RTL and testbench
====================================

Name: slicel_cfg_loader

Overview:
- Configuration writer for one slicel.
- Accepts the slicel bitstream (143 bits at default parameters) as a ready/valid stream of WORD_W-bit beats and assembles it in a shadow register.
- Commits the assembled word atomically onto the slicel's parallel configuration ports, then drives cen low so the slicel enters run mode.
- Replaces bench-side direct driving of the slicel config ports; sits between the fabric config network and each slicel.

Parameters:
- S_XX_BASE, 4, LUT input width base; must match the slicel.
- NUM_LUTS, 4, LUTs per slicel.
- MUX_LVLS, $clog2(NUM_LUTS), inter-LUT mux config bits.
- CFG_SIZE, 2*(2**S_XX_BASE)+1, config bits per LUT (33).
- WORD_W, 8, stream beat width.
- TOTAL_BITS, CFG_SIZE*NUM_LUTS+MUX_LVLS+1+2*NUM_LUTS, bitstream length (143).
- NUM_BEATS, ceil(TOTAL_BITS/WORD_W), data beats per load (18).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load.
- cfg_valid  in  1  beat valid.
- cfg_ready  out  1  beat accepted when cfg_valid & cfg_ready.
- cfg_data  in  WORD_W  beat payload.
- luts_config_in  out  CFG_SIZE*NUM_LUTS  committed LUT config, bits [131:0].
- inter_lut_mux_config  out  MUX_LVLS  committed, bits [133:132].
- config_use_cc  out  1  committed, bit [134].
- regs_config_in  out  2*NUM_LUTS  committed, bits [142:135].
- cen  out  1  slicel config enable; 1 = configuring, 0 = run.
- busy  out  1  high in SHIFT or COMMIT.
- done  out  1  one-cycle pulse on successful commit.
- err  out  1  sticky until next start or rst; set on a failed load.

Behaviour:
- Reset values: all committed config outputs 0; cen=1; cfg_ready=0; busy=0; done=0; err=0; state IDLE; beat counter 0.
- Reset is synchronous and active-high, and takes priority in every state. rst during SHIFT discards the shadow register and returns the block to reset values; a partial bitstream is never committed.
- Bit order: beat k carries bitstream bits [k*WORD_W +: WORD_W], LSB-first. Bits at or above TOTAL_BITS in the last beat (bit 143 at defaults) are ignored.
- IDLE:
  - cfg_ready=0.
  - start -> SHIFT next cycle; clears err and beat counter; cen=1 from the cycle after start.
- SHIFT:
  - cfg_ready=1, registered.
  - Each accepted beat writes the shadow register and increments the counter.
  - cfg_valid low stalls indefinitely with no timeout.
  - Acceptance of beat NUM_BEATS-1 -> COMMIT (or -> CHECK when CFG_CHECK_EN is defined).
  - start in SHIFT is ignored.
- COMMIT:
  - Single cycle; cfg_ready=0.
  - Shadow register copied to all config outputs at the end of this cycle; cen stays 1.
  - -> DONE.
- DONE:
  - cen=0 and done=1 for this cycle only.
  - Committed outputs held stable.
  - -> IDLE, with cen remaining 0.
  - A later start raises cen to 1 again for reconfiguration.
- Latency:
  - Final beat accepted in cycle t: outputs valid at t+2, cen falls at t+2.
  - Minimum load: 1 (start) + NUM_BEATS + 2 cycles.
- Committed outputs change only in COMMIT; the slicel never sees a partially updated word.
- Beats with cfg_valid=1 outside SHIFT are not accepted (cfg_ready=0) and have no effect.

Optional Feature:
- Macro: CFG_CHECK_EN.
- Defined:
  - One extra beat follows the data beats: the checksum, equal to the XOR of all NUM_BEATS data beats with ignored pad bits treated as 0.
  - State CHECK accepts this beat.
  - Match -> COMMIT.
  - Mismatch -> err=1, no commit, cen stays 1, -> IDLE.
- Undefined: no CHECK state, no checksum beat, err is tied 0.

Test Plan:
- Reset: hold rst 2 cycles -> all config outputs 0, cen=1, cfg_ready=0, done=0.
- Basic load: start, then 18 back-to-back beats forming the pattern luts=132'h0..0F_0F, mux=2'b10, use_cc=1, regs=8'hA5 -> at t+2 outputs equal those exact values, cen 1->0, done pulses exactly once; total 21 cycles from start.
- Stall: same load with cfg_valid deasserted for 3 cycles after beats 4 and 17 -> identical outputs, committed 6 cycles later than basic; outputs unchanged before commit.
- Reset mid-load: rst after beat 9 of a new load that follows a prior committed load -> outputs 0, cen=1, done never pulses.
- Reconfig and pad: second load with pad bit 143 set to 1 -> regs_config_in reflects only bits [142:135]; cen high from the cycle after start until commit; old config held until commit.
- With CFG_CHECK_EN: correct checksum -> commit and done; checksum XOR 8'h01 -> err=1, outputs hold prior config, cen stays 1.

Source files
------------

// File: rtl/slicel_cfg_loader.sv
// slicel_cfg_loader
// Configuration writer for one slicel. The bitstream arrives as a ready/valid
// stream of WORD_W-bit beats (beat k carries bits [k*WORD_W +: WORD_W],
// LSB-first). It is assembled in a shadow register and then copied in a single
// cycle onto the slicel's parallel config ports, after which cen drops so the
// slicel enters run mode.
// Optional feature macro: CFG_CHECK_EN adds a trailing checksum beat (XOR of
// all data beats, pad bits as 0); a mismatch sets err and skips the commit.
module slicel_cfg_loader #(
  parameter int S_XX_BASE  = 4,
  parameter int NUM_LUTS   = 4,
  parameter int MUX_LVLS   = $clog2(NUM_LUTS),
  parameter int CFG_SIZE   = 2*(2**S_XX_BASE)+1,
  parameter int WORD_W     = 8,
  parameter int TOTAL_BITS = CFG_SIZE*NUM_LUTS+MUX_LVLS+1+2*NUM_LUTS,
  parameter int NUM_BEATS  = (TOTAL_BITS+WORD_W-1)/WORD_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [WORD_W-1:0]            cfg_data,
  output logic [CFG_SIZE*NUM_LUTS-1:0] luts_config_in,
  output logic [MUX_LVLS-1:0]          inter_lut_mux_config,
  output logic                         config_use_cc,
  output logic [2*NUM_LUTS-1:0]        regs_config_in,
  output logic                         cen,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  // Field positions inside the assembled bitstream.
  localparam int LUT_BITS = CFG_SIZE*NUM_LUTS;
  localparam int MUX_LSB  = LUT_BITS;
  localparam int CC_BIT   = LUT_BITS + MUX_LVLS;
  localparam int REG_LSB  = CC_BIT + 1;
  localparam int CNT_W    = $clog2(NUM_BEATS+1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS-1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
`ifdef CFG_CHECK_EN
    ST_CHECK  = 3'd4,
`endif
    ST_COMMIT = 3'd2,
    ST_DONE   = 3'd3
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic              cfg_ready_q;
  logic              cen_q;
  logic              ready_nxt;
  logic              beat_acc;
  logic              shift_we;
  logic              last_beat;
  logic              load_go;
  logic              commit_en;

  // Shadow beats (stage 0) and committed word (stage 1).
  logic [WORD_W-1:0]     beats_p0 [NUM_BEATS];
  logic [TOTAL_BITS-1:0] shadow_p0;
  logic [TOTAL_BITS-1:0] commit_p1;

  assign beat_acc  = cfg_valid && cfg_ready_q;
  assign shift_we  = beat_acc && (state_q == ST_SHIFT);
  assign last_beat = (cnt_q == LAST_BEAT);

`ifdef CFG_CHECK_EN
  logic [WORD_W-1:0] chk_acc;
  logic              chk_ok;
  logic              err_q;

  // Clears the bits of a beat that fall beyond the end of the bitstream.
  function automatic logic [WORD_W-1:0] pad_mask(input logic [CNT_W-1:0] beat);
    logic [WORD_W-1:0] m;
    for (int j = 0; j < WORD_W; j++)
      m[j] = ((int'(beat) * WORD_W + j) < TOTAL_BITS);
    return m;
  endfunction

  assign chk_ok = (cfg_data == chk_acc);
`endif

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (beat_acc && last_beat) begin
`ifdef CFG_CHECK_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_COMMIT;
`endif
        end
      end
`ifdef CFG_CHECK_EN
      ST_CHECK: begin
        if (beat_acc) state_nxt = chk_ok ? ST_COMMIT : ST_IDLE;
      end
`endif
      ST_COMMIT: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output and strobe decode from the current/next state.
  always_comb begin
    load_go   = (state_q == ST_IDLE) && start;
    commit_en = (state_q == ST_COMMIT);
    done      = (state_q == ST_DONE);
`ifdef CFG_CHECK_EN
    busy      = (state_q == ST_SHIFT) || (state_q == ST_CHECK) || (state_q == ST_COMMIT);
    ready_nxt = (state_nxt == ST_SHIFT) || (state_nxt == ST_CHECK);
`else
    busy      = (state_q == ST_SHIFT) || (state_q == ST_COMMIT);
    ready_nxt = (state_nxt == ST_SHIFT);
`endif
  end

  // Control state: FSM, beat counter, registered ready and cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cfg_ready_q <= 1'b0;
      cen_q       <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      cfg_ready_q <= ready_nxt;
      if (load_go)
        cnt_q <= '0;
      else if (shift_we && !last_beat)
        cnt_q <= cnt_q + CNT_W'(1);
      if (load_go)
        cen_q <= 1'b1;
      else if (commit_en)
        cen_q <= 1'b0;
    end
  end

  // ---- stage 0: beat capture into the shadow register ----
  // Shadow data carries no reset; a load always overwrites every beat before commit.
  always_ff @(posedge clk) begin
    if (shift_we)
      beats_p0[cnt_q] <= cfg_data;
  end

  // Flatten beats into the bitstream; pad bits of the final beat are dropped.
  for (genvar g = 0; g < NUM_BEATS; g++) begin : g_flat
    localparam int LSB = g * WORD_W;
    localparam int W   = ((TOTAL_BITS - LSB) < WORD_W) ? (TOTAL_BITS - LSB) : WORD_W;
    assign shadow_p0[LSB +: W] = beats_p0[g][W-1:0];
  end

`ifdef CFG_CHECK_EN
  // Running XOR of accepted data beats, restarted on each load.
  always_ff @(posedge clk) begin
    if (load_go)
      chk_acc <= '0;
    else if (shift_we)
      chk_acc <= chk_acc ^ (cfg_data & pad_mask(cnt_q));
  end

  // Sticky error flag for a checksum mismatch, cleared by the next start.
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (load_go)
      err_q <= 1'b0;
    else if ((state_q == ST_CHECK) && beat_acc && !chk_ok)
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // ---- stage 1: atomic commit onto the slicel config ports ----
  // Committed word only changes in COMMIT so the slicel never sees a partial update.
  always_ff @(posedge clk) begin
    if (rst)
      commit_p1 <= '0;
    else if (commit_en)
      commit_p1 <= shadow_p0;
  end

  assign cfg_ready            = cfg_ready_q;
  assign cen                  = cen_q;
  assign luts_config_in       = commit_p1[LUT_BITS-1:0];
  assign inter_lut_mux_config = commit_p1[MUX_LSB +: MUX_LVLS];
  assign config_use_cc        = commit_p1[CC_BIT];
  assign regs_config_in       = commit_p1[REG_LSB +: 2*NUM_LUTS];

endmodule

// File: tb/tb_slicel_cfg_loader.sv
// Self-checking bench for slicel_cfg_loader: table of full loads plus
// hand-written reset, idle-beat and checksum sequences.
module tb_slicel_cfg_loader;

  localparam int NUM_BEATS = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [7:0]   cfg_data;
  logic [131:0] luts_config_in;
  logic [1:0]   inter_lut_mux_config;
  logic         config_use_cc;
  logic [7:0]   regs_config_in;
  logic         cen;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  slicel_cfg_loader dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .cfg_valid            (cfg_valid),
    .cfg_ready            (cfg_ready),
    .cfg_data             (cfg_data),
    .luts_config_in       (luts_config_in),
    .inter_lut_mux_config (inter_lut_mux_config),
    .config_use_cc        (config_use_cc),
    .regs_config_in       (regs_config_in),
    .cen                  (cen),
    .busy                 (busy),
    .done                 (done),
    .err                  (err)
  );

  typedef struct {
    logic [131:0] luts;
    logic [1:0]   mux;
    logic         cc;
    logic [7:0]   regs;
    logic         pad;
    int           stall_a;
    int           stall_b;
    int           start_at;
    int           exp_edges;
  } vec_t;

  vec_t vecs [5];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [142:0] act, input logic [142:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [142:0] cur_cfg();
    return {regs_config_in, config_use_cc, inter_lut_mux_config, luts_config_in};
  endfunction

  function automatic logic [7:0] model_chk(input logic [143:0] b);
    logic [143:0] m;
    logic [7:0]   x;
    m = b;
    m[143] = 1'b0;
    x = '0;
    for (int i = 0; i < NUM_BEATS; i++) x ^= m[i*8 +: 8];
    return x;
  endfunction

  // Results of the most recent run_load.
  int           r_done_edge;
  int           r_done_cnt;
  bit           r_hold_bad;
  bit           r_cen_bad;
  bit           r_busy_bad;
  logic [142:0] r_cfg;
  logic         r_cen_done;
  logic [142:0] r_cfg_post;
  logic         r_cen_post;

  // Start a load and stream it; observes the DUT each cycle. Called at a sample point.
  task automatic run_load(input logic [143:0] bits, input logic [142:0] old_cfg,
                          input int stall_a, input int stall_b, input int start_at,
                          input logic [7:0] chk_flip);
    int   n, k, stall, nb;
    logic rdy;
    nb = NUM_BEATS;
`ifdef CFG_CHECK_EN
    nb = NUM_BEATS + 1;
`endif
    r_done_edge = -1; r_done_cnt = 0;
    r_hold_bad = 0; r_cen_bad = 0; r_busy_bad = 0;
    r_cfg = '0; r_cen_done = 1'b1; r_cfg_post = '0; r_cen_post = 1'b1;
    start = 1'b1; cfg_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; k = 0; stall = 0;
    while (n < 80 && !(r_done_edge >= 0 && n > r_done_edge + 1)) begin
      if (done) begin
        r_done_cnt++;
        if (r_done_edge < 0) begin
          r_done_edge = n;
          r_cfg = cur_cfg();
          r_cen_done = cen;
        end
      end else if (r_done_edge < 0) begin
        if (cur_cfg() !== old_cfg) r_hold_bad = 1;
        if (cen !== 1'b1) r_cen_bad = 1;
        if (k < nb && busy !== 1'b1) r_busy_bad = 1;
      end
      if (r_done_edge >= 0 && n == r_done_edge + 1) begin
        r_cfg_post = cur_cfg();
        r_cen_post = cen;
      end
      rdy = cfg_ready;
      start = (start_at >= 0) && (k == start_at);
      if (stall > 0) begin
        cfg_valid = 1'b0;
        stall--;
      end else if (k < nb) begin
        cfg_valid = 1'b1;
        if (k < NUM_BEATS) cfg_data = bits[k*8 +: 8];
        else cfg_data = model_chk(bits) ^ chk_flip;
      end else begin
        cfg_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (cfg_valid && rdy) begin
        k++;
        if (k == stall_a || k == stall_b) stall = 3;
      end
    end
    start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    logic [142:0] old_cfg;
    logic [142:0] exp_cfg;
    logic [143:0] bits;
    int           exp_e;
    int           dn, rd, kk, nn;
    bit           changed;
    logic         rdy;

    vecs[0] = '{luts: 132'h0F0F, mux: 2'b10, cc: 1'b1, regs: 8'hA5, pad: 1'b0,
                stall_a: -1, stall_b: -1, start_at: -1, exp_edges: 20};
    vecs[1] = '{luts: 132'h0F0F, mux: 2'b10, cc: 1'b1, regs: 8'hA5, pad: 1'b0,
                stall_a: 4, stall_b: 17, start_at: -1, exp_edges: 26};
    vecs[2] = '{luts: 132'hF_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, mux: 2'b01, cc: 1'b0,
                regs: 8'h3C, pad: 1'b1, stall_a: -1, stall_b: -1, start_at: 5, exp_edges: 20};
    vecs[3] = '{luts: 132'h0, mux: 2'b00, cc: 1'b0, regs: 8'h00, pad: 1'b1,
                stall_a: -1, stall_b: -1, start_at: -1, exp_edges: 20};
    vecs[4] = '{luts: {132{1'b1}}, mux: 2'b11, cc: 1'b1, regs: 8'hFF, pad: 1'b1,
                stall_a: -1, stall_b: -1, start_at: -1, exp_edges: 20};

    // Reset held for two cycles.
    rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg", cur_cfg(), 143'(0));
    chk("rst_cen", 143'(cen), 143'(1));
    chk("rst_ready", 143'(cfg_ready), 143'(0));
    chk("rst_done", 143'(done), 143'(0));
    chk("rst_busy", 143'(busy), 143'(0));
    chk("rst_err", 143'(err), 143'(0));
    rst = 1'b0;

    // Beats offered while idle are refused and change nothing.
    rd = 0; changed = 0;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_data = 8'hFF;
      @(posedge clk); #1;
      if (cfg_ready) rd++;
      if (cur_cfg() !== 143'(0) || cen !== 1'b1) changed = 1;
    end
    cfg_valid = 1'b0;
    chk("idle_ready", 143'(rd), 143'(0));
    chk("idle_hold", 143'(changed), 143'(0));

    // Table of full loads.
    old_cfg = '0;
    for (int i = 0; i < 5; i++) begin
      exp_cfg = {vecs[i].regs, vecs[i].cc, vecs[i].mux, vecs[i].luts};
      bits    = {vecs[i].pad, exp_cfg};
      exp_e   = vecs[i].exp_edges;
`ifdef CFG_CHECK_EN
      exp_e   = exp_e + 1;
`endif
      run_load(bits, old_cfg, vecs[i].stall_a, vecs[i].stall_b, vecs[i].start_at, 8'h00);
      chk($sformatf("v%0d_done_lat", i), 143'(r_done_edge), 143'(exp_e));
      chk($sformatf("v%0d_done_cnt", i), 143'(r_done_cnt), 143'(1));
      chk($sformatf("v%0d_cfg", i), r_cfg, exp_cfg);
      chk($sformatf("v%0d_cen_done", i), 143'(r_cen_done), 143'(0));
      chk($sformatf("v%0d_hold_old", i), 143'(r_hold_bad), 143'(0));
      chk($sformatf("v%0d_cen_high", i), 143'(r_cen_bad), 143'(0));
      chk($sformatf("v%0d_busy", i), 143'(r_busy_bad), 143'(0));
      chk($sformatf("v%0d_post_cfg", i), r_cfg_post, exp_cfg);
      chk($sformatf("v%0d_post_cen", i), 143'(r_cen_post), 143'(0));
      chk($sformatf("v%0d_err", i), 143'(err), 143'(0));
      old_cfg = exp_cfg;
    end

    // Reset in the middle of a reconfiguration.
    bits = {1'b0, 8'h5A, 1'b1, 2'b01, 132'h1234_5678_9ABC_DEF0_1357};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    kk = 0; nn = 0;
    while (kk < 9 && nn < 40) begin
      rdy = cfg_ready;
      cfg_valid = 1'b1; cfg_data = bits[kk*8 +: 8];
      @(posedge clk); #1;
      nn++;
      if (rdy) kk++;
    end
    cfg_valid = 1'b0;
    chk("mid_beats", 143'(kk), 143'(9));
    chk("mid_hold_old", cur_cfg(), old_cfg);
    chk("mid_cen", 143'(cen), 143'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_cfg", cur_cfg(), 143'(0));
    chk("mid_rst_cen", 143'(cen), 143'(1));
    chk("mid_rst_ready", 143'(cfg_ready), 143'(0));
    chk("mid_rst_busy", 143'(busy), 143'(0));
    dn = 0; rd = 0; changed = 0;
    for (int i = 0; i < 25; i++) begin
      cfg_valid = 1'b1; cfg_data = bits[(i % NUM_BEATS)*8 +: 8];
      @(posedge clk); #1;
      if (done) dn++;
      if (cfg_ready) rd++;
      if (cur_cfg() !== 143'(0) || cen !== 1'b1) changed = 1;
    end
    cfg_valid = 1'b0;
    chk("mid_no_done", 143'(dn), 143'(0));
    chk("mid_no_ready", 143'(rd), 143'(0));
    chk("mid_idle_hold", 143'(changed), 143'(0));

    // Recovery load from the reset state.
    old_cfg = '0;
    exp_cfg = {vecs[0].regs, vecs[0].cc, vecs[0].mux, vecs[0].luts};
    exp_e   = 20;
`ifdef CFG_CHECK_EN
    exp_e   = 21;
`endif
    run_load({1'b0, exp_cfg}, old_cfg, -1, -1, -1, 8'h00);
    chk("rec_done_lat", 143'(r_done_edge), 143'(exp_e));
    chk("rec_cfg", r_cfg, exp_cfg);
    chk("rec_hold_old", 143'(r_hold_bad), 143'(0));
    old_cfg = exp_cfg;

`ifdef CFG_CHECK_EN
    // Corrupted checksum: no commit, err set, cen stays high.
    run_load({1'b1, 8'h66, 1'b0, 2'b11, 132'hABCD_EF01}, old_cfg, -1, -1, -1, 8'h01);
    chk("bad_done_cnt", 143'(r_done_cnt), 143'(0));
    chk("bad_hold_old", 143'(r_hold_bad), 143'(0));
    chk("bad_cen_high", 143'(r_cen_bad), 143'(0));
    chk("bad_cfg", cur_cfg(), old_cfg);
    chk("bad_err", 143'(err), 143'(1));
    chk("bad_busy", 143'(busy), 143'(0));
    // A following good load clears err and commits.
    exp_cfg = {8'h66, 1'b0, 2'b11, 132'hABCD_EF01};
    run_load({1'b1, exp_cfg}, old_cfg, -1, -1, -1, 8'h00);
    chk("good_done_lat", 143'(r_done_edge), 143'(21));
    chk("good_cfg", r_cfg, exp_cfg);
    chk("good_err", 143'(err), 143'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
